// File: rtl/axi_lite_master_if.sv
// ============================================================================
// axi_lite_if : AXI4-Lite channel bundle (AW/W/B/AR/R) with master/slave views
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_W-1:0]     araddr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

`default_nettype wire

// File: rtl/axi_lite_master.sv
// ============================================================================
// axi_lite_master : single-outstanding bridge from core load/store pulses to AXI4-Lite
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_lite_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   axi_lite_if.master          m
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4
   } state_t;

   state_t                state;
   logic                  aw_pend;
   logic                  w_pend;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;

   assign req_ready = (state == IDLE);

   // Every AXI valid/ready is a pure decode of registers, so the async reset
   // drops them immediately and no slave input can loop back combinationally.
   assign m.arvalid = (state == RD_ADDR);
   assign m.rready  = (state == RD_DATA);
   assign m.awvalid = (state == WR_REQ) && aw_pend;
   assign m.wvalid  = (state == WR_REQ) && w_pend;
   assign m.bready  = (state == WR_RESP);
   assign m.araddr  = addr_q;
   assign m.awaddr  = addr_q;
   assign m.wdata   = wdata_q;
   assign m.wstrb   = wstrb_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         aw_pend   <= 1'b0;
         w_pend    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  wstrb_q <= req_wstrb;
                  if (req_we) begin
                     aw_pend <= 1'b1;
                     w_pend  <= 1'b1;
                     state   <= WR_REQ;
                  end else begin
                     state   <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (m.arready) state <= RD_DATA;
            end
            RD_DATA: begin
               if (m.rvalid) begin
                  rsp_rdata <= m.rdata;
                  rsp_err   <= (m.rresp != 2'b00);
                  rsp_valid <= 1'b1;
                  state     <= IDLE;
               end
            end
            WR_REQ: begin
               // A channel that already finished has valid low, so its ready is ignored.
               if (aw_pend && m.awready) aw_pend <= 1'b0;
               if (w_pend && m.wready)   w_pend  <= 1'b0;
               if ((!aw_pend || m.awready) && (!w_pend || m.wready))
                  state <= WR_RESP;
            end
            WR_RESP: begin
               if (m.bvalid) begin
                  rsp_rdata <= '0;
                  rsp_err   <= (m.bresp != 2'b00);
                  rsp_valid <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// ============================================================================
// tb_axi_lite_master : scoreboard bench with a configurable-latency AXI4-Lite slave
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_master;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   always #5 clk = ~clk;

   axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .m         (bus)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   rsp_count = 0;

   // slave behaviour knobs
   int          aw_delay = 0;
   int          w_delay = 0;
   int          ar_delay = 0;
   logic [31:0] rdata_val = '0;
   logic [1:0]  rresp_val = 2'b00;
   logic [1:0]  bresp_val = 2'b00;

   // slave handshake bookkeeping
   logic        r_pend = 1'b0, b_pend = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
   int          b_hs_n = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0;
   logic [3:0]  cap_wstrb = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!reset_n) begin
         r_pend  <= 1'b0;
         b_pend  <= 1'b0;
         aw_seen <= 1'b0;
         w_seen  <= 1'b0;
      end else begin
         if (bus.arvalid && bus.arready) r_pend <= 1'b1;
         else if (bus.rvalid && bus.rready) r_pend <= 1'b0;
         if (bus.awvalid && bus.awready) begin
            cap_awaddr <= bus.awaddr;
            aw_hs_cyc  <= cyc;
         end
         if (bus.wvalid && bus.wready) begin
            cap_wdata <= bus.wdata;
            cap_wstrb <= bus.wstrb;
            w_hs_cyc  <= cyc;
         end
         if ((aw_seen || (bus.awvalid && bus.awready)) && (w_seen || (bus.wvalid && bus.wready))) begin
            b_pend  <= 1'b1;
            aw_seen <= 1'b0;
            w_seen  <= 1'b0;
         end else begin
            if (bus.awvalid && bus.awready) aw_seen <= 1'b1;
            if (bus.wvalid && bus.wready)   w_seen  <= 1'b1;
            if (bus.bvalid && bus.bready) begin
               b_pend <= 1'b0;
               b_hs_n <= b_hs_n + 1;
            end
         end
      end
   end

   initial begin
      int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
      bus.bvalid = 1'b0; bus.bresp = 2'b00;
      forever begin
         @(negedge clk);
         if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_delay); aw_cnt++; end
         else begin bus.awready = 1'b0; aw_cnt = 0; end
         if (bus.wvalid) begin bus.wready = (w_cnt >= w_delay); w_cnt++; end
         else begin bus.wready = 1'b0; w_cnt = 0; end
         if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_delay); ar_cnt++; end
         else begin bus.arready = 1'b0; ar_cnt = 0; end
         bus.rvalid = r_pend;
         bus.rdata  = r_pend ? rdata_val : 32'h0;
         bus.rresp  = rresp_val;
         bus.bvalid = b_pend;
         bus.bresp  = bresp_val;
      end
   end

   task automatic monitor();
      rsp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && rsp_valid) begin
            rsp_count++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
            end else begin
               e = exp_q.pop_front();
               if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                  n_err++;
                  $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                           rsp_rdata, rsp_err, e.rdata, e.err);
               end
            end
         end
      end
   endtask

   // Presents a request at the current negedge, returns at the negedge after acceptance.
   task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [31:0] e_rd, input logic e_err,
                            input bit push, output int acc_cyc);
      rsp_t e;
      int k;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      if (push) begin e.rdata = e_rd; e.err = e_err; exp_q.push_back(e); end
      for (k = 0; k < 50 && !req_ready; k++) @(negedge clk);
      if (!req_ready) begin
         n_cmp++; n_err++;
         $display("FAIL req_accept_timeout: req_ready=%b, required 1", req_ready);
      end
      acc_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int rcyc);
      int k;
      for (k = 0; k < 40 && !rsp_valid; k++) @(negedge clk);
      if (!rsp_valid) begin
         n_cmp++; n_err++;
         $display("FAIL rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
      end
      rcyc = cyc;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
      n_cmp++;
      if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_axi_valids: got %b required 00000",
                  {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
      end
      n_cmp++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_rsp: got %b/%h/%b required 0/0/0", rsp_valid, rsp_rdata, rsp_err);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read();
      int n;
      rdata_val = 32'hDEADBEEF; rresp_val = 2'b00; ar_delay = 0;
      start_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, n);
      n_cmp++;
      if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0010) begin
         n_err++; $display("FAIL rd_arvalid_n1: got arvalid=%b araddr=%h required 1/80000010", bus.arvalid, bus.araddr);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.rready !== 1'b1 || bus.arvalid !== 1'b0) begin
         n_err++; $display("FAIL rd_rready_n2: got rready=%b arvalid=%b required 1/0", bus.rready, bus.arvalid);
      end
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || bus.rready !== 1'b0 || cyc != n + 3) begin
         n_err++; $display("FAIL rd_rsp_n3: got rsp_valid=%b req_ready=%b rready=%b required 1/1/0", rsp_valid, req_ready, bus.rready);
      end
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL rd_rsp_hold: got rsp_valid=%b rdata=%h required 0/deadbeef", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_write_aw_stall();
      int n, k, aw_hi = 0, w_hi = 0, bad = 0;
      aw_delay = 3; w_delay = 0; bresp_val = 2'b00;
      start_req(1'b1, 32'ha00003f8, 32'h41, 4'h1, 32'h0, 1'b0, 1'b1, n);
      for (k = 0; k < 30 && !rsp_valid; k++) begin
         aw_hi += int'(bus.awvalid);
         w_hi  += int'(bus.wvalid);
         if (bus.awvalid && bus.awaddr !== 32'ha00003f8) bad++;
         if (bus.bready && (bus.awvalid || bus.wvalid)) bad++;
         @(negedge clk);
      end
      n_cmp++;
      if (aw_hi != 4 || w_hi != 1) begin
         n_err++; $display("FAIL wr_aw_stall_valids: got aw_cycles=%0d w_cycles=%0d required 4/1", aw_hi, w_hi);
      end
      n_cmp++;
      if (cyc != n + 6 || bad != 0) begin
         n_err++; $display("FAIL wr_aw_stall_timing: got rsp at +%0d bad=%0d required +6/0", cyc - n, bad);
      end
      n_cmp++;
      if (cap_awaddr !== 32'ha00003f8 || cap_wdata !== 32'h41 || cap_wstrb !== 4'h1) begin
         n_err++; $display("FAIL wr_aw_stall_payload: got %h/%h/%h required a00003f8/00000041/1", cap_awaddr, cap_wdata, cap_wstrb);
      end
      @(negedge clk);
      aw_delay = 0;
   endtask

   task automatic test_write_w_late();
      int n, k, b0, r0, bad = 0;
      aw_delay = 0; w_delay = 2;
      b0 = b_hs_n; r0 = rsp_count;
      start_req(1'b1, 32'h1000_0004, 32'hCAFEF00D, 4'hC, 32'h0, 1'b0, 1'b1, n);
      for (k = 0; k < 30 && !rsp_valid; k++) begin
         if (bus.wvalid && (bus.wdata !== 32'hCAFEF00D || bus.wstrb !== 4'hC)) bad++;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (!(aw_hs_cyc < w_hs_cyc) || bad != 0) begin
         n_err++; $display("FAIL wr_w_late_order: got aw_cyc=%0d w_cyc=%0d bad=%0d required aw<w, 0", aw_hs_cyc, w_hs_cyc, bad);
      end
      n_cmp++;
      if (b_hs_n - b0 != 1 || rsp_count - r0 != 1) begin
         n_err++; $display("FAIL wr_w_late_count: got b=%0d rsp=%0d required 1/1", b_hs_n - b0, rsp_count - r0);
      end
      n_cmp++;
      if (cap_wdata !== 32'hCAFEF00D || cap_wstrb !== 4'hC || cap_awaddr !== 32'h1000_0004) begin
         n_err++; $display("FAIL wr_w_late_payload: got %h/%h/%h required 10000004/cafef00d/c", cap_awaddr, cap_wdata, cap_wstrb);
      end
      w_delay = 0;
   endtask

   task automatic test_error();
      int n, rc;
      rdata_val = 32'h1234_5678; rresp_val = 2'b10;
      start_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 1'b1, n);
      wait_rsp(rc);
      n_cmp++;
      if (rsp_err !== 1'b1) begin n_err++; $display("FAIL rd_slverr: got rsp_err=%b required 1", rsp_err); end
      @(negedge clk);
      rresp_val = 2'b00; bresp_val = 2'b11;
      start_req(1'b1, 32'hF000_0000, 32'h77, 4'hF, 32'h0, 1'b1, 1'b1, n);
      wait_rsp(rc);
      n_cmp++;
      if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
         n_err++; $display("FAIL wr_decerr: got err=%b rdata=%h required 1/0", rsp_err, rsp_rdata);
      end
      @(negedge clk);
      bresp_val = 2'b00; rdata_val = 32'h0000_00A5;
      start_req(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0000_00A5, 1'b0, 1'b1, n);
      wait_rsp(rc);
      n_cmp++;
      if (rsp_err !== 1'b0 || rc != n + 3) begin
         n_err++; $display("FAIL after_err_ok: got err=%b latency=%0d required 0/3", rsp_err, rc - n);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n, k, r0, rc;
      rsp_t e;
      r0 = rsp_count;
      rdata_val = 32'h0BAD_F00D;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2000_0000;
      e.rdata = 32'h0BAD_F00D; e.err = 1'b0; exp_q.push_back(e);
      for (k = 0; k < 20 && !req_ready; k++) @(negedge clk);
      n = cyc;
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h2000_0008; req_wdata = 32'h55AA_55AA; req_wstrb = 4'hF;
      e.rdata = 32'h0; e.err = 1'b0; exp_q.push_back(e);
      for (k = 0; k < 20 && !req_ready; k++) @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || cyc != n + 3) begin
         n_err++; $display("FAIL b2b_accept: got rsp_valid=%b at +%0d required 1 at +3", rsp_valid, cyc - n);
      end
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(rc);
      n_cmp++;
      if (rc != n + 6) begin
         n_err++; $display("FAIL b2b_second_rsp: got +%0d required +6", rc - n);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (rsp_count - r0 != 2) begin
         n_err++; $display("FAIL b2b_pulses: got %0d required 2", rsp_count - r0);
      end
   endtask

   task automatic test_reset_mid();
      int n, r0;
      r0 = rsp_count;
      aw_delay = 1000;
      start_req(1'b1, 32'h3000_0000, 32'h99, 4'h3, 32'h0, 1'b0, 1'b0, n);
      n_cmp++;
      if (bus.awvalid !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre: got awvalid=%b required 1", bus.awvalid); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 || req_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_async: got awvalid=%b wvalid=%b req_ready=%b required 0/0/1", bus.awvalid, bus.wvalid, req_ready);
      end
      repeat (2) @(negedge clk);
      aw_delay = 0;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_count != r0 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_after: got req_ready=%b extra_rsp=%0d required 1/0", req_ready, rsp_count - r0);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_read();
      test_write_aw_stall();
      test_write_w_late();
      test_error();
      test_back_to_back();
      test_reset_mid();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
